mtime_tick_gen: RTL and testbench

- Machine-timer tick source that drives the watchdog down-counter.
- Divides `sys_clk` by a programmable prescaler to produce a one-cycle `mtick` enable pulse.
- Keeps a 64-bit RISC-V style `mtime` counter and `mtimecmp` compare register, and raises the timer interrupt `mtip`.
- Software configures it through a simple 32-bit register port. Consumers use `mtick` as a clock enable in the `sys_clk` domain.

---
 rtl/mtime_pkg.sv | 19 +
 rtl/mtime_tick_gen_if.sv | 14 +
 rtl/mtick_prescaler.sv | 25 ++
 rtl/mtime_tick_gen.sv | 101 ++++++++++
 tb/tb_mtime_tick_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mtime_pkg.sv
// Shared register map and reset constants for the machine-timer tick block.
package mtime_pkg;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_MTIME_LO    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MTIME_HI    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_LO = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_HI = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CTRL        = 3'd5;

  localparam int CTRL_EN_BIT = 0;
  localparam logic [63:0] MTIMECMP_RST = '1;

  // Writes to these registers restart the prescale period.
  function automatic logic is_cfg_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_PRESCALE) || (a == ADDR_CTRL);
  endfunction
endpackage

// File: rtl/mtime_tick_gen_if.sv
// Single-cycle request / one-cycle-later ack register port.
interface mtime_tick_gen_if;
  import mtime_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mtick_prescaler.sv
// Prescale counter; tick is raised combinationally on the last cycle of a period.
module mtick_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 res,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] prescale,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || tick) cnt_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mtime_tick_gen.sv
// Machine-timer tick source: prescaled mtick pulse, 64-bit mtime/mtimecmp and mtip.
module mtime_tick_gen
  import mtime_pkg::*;
#(
  parameter int                   DIV_WIDTH        = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_PRESCALE = DIV_WIDTH'(999)
) (
  input  logic               sys_clk,
  input  logic               res,
  mtime_tick_gen_if.slave    bus,
  output logic               mtick,
  output logic [63:0]        mtime_o,
  output logic               mtip
);
  logic [63:0]          mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [DIV_WIDTH-1:0] prescale_q, prescale_d;
  logic                 en_q, en_d;
  logic [31:0]          hi_shadow_q, hi_shadow_d, rdata_q, rdata_d;
  logic                 ack_q, mtick_q, mtip_q;
  logic                 wr, rd, cfg_wr, tick_raw, tick;

  assign wr     = bus.req && bus.we;
  assign rd     = bus.req && !bus.we;
  assign cfg_wr = wr && is_cfg_addr(bus.addr);
  // The reconfiguring edge starts a fresh period, so it never ticks itself.
  assign tick   = tick_raw && !cfg_wr;

  mtick_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .sys_clk  (sys_clk),
    .res      (res),
    .en       (en_q),
    .clr      (cfg_wr),
    .prescale (prescale_q),
    .tick     (tick_raw)
  );

  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    prescale_d  = prescale_q;
    en_d        = en_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = '0;
    // A bus write to mtime overrides a coincident tick increment.
    if (wr) begin
      case (bus.addr)
        ADDR_MTIME_LO:    mtime_d          = {mtime_q[63:32], bus.wdata};
        ADDR_MTIME_HI:    mtime_d          = {bus.wdata, mtime_q[31:0]};
        ADDR_MTIMECMP_LO: mtimecmp_d[31:0] = bus.wdata;
        ADDR_MTIMECMP_HI: mtimecmp_d[63:32] = bus.wdata;
        ADDR_PRESCALE:    prescale_d       = bus.wdata[DIV_WIDTH-1:0];
        ADDR_CTRL:        en_d             = bus.wdata[CTRL_EN_BIT];
        default: ;
      endcase
    end
    if (rd) begin
      case (bus.addr)
        ADDR_MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        ADDR_MTIME_HI:    rdata_d = hi_shadow_q;
        ADDR_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        ADDR_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        ADDR_PRESCALE:    rdata_d = 32'(prescale_q);
        ADDR_CTRL:        rdata_d[CTRL_EN_BIT] = en_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (res) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RST;
      prescale_q  <= DEFAULT_PRESCALE;
      en_q        <= 1'b0;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      mtick_q     <= 1'b0;
      mtip_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      prescale_q  <= prescale_d;
      en_q        <= en_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      ack_q       <= bus.req;
      mtick_q     <= tick;
      mtip_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign mtick     = mtick_q;
  assign mtime_o   = mtime_q;
  assign mtip      = mtip_q;
endmodule

// File: tb/tb_mtime_tick_gen.sv
// Random and directed stimulus for mtime_tick_gen against an in-bench reference model.
module tb_mtime_tick_gen;
  logic        sys_clk = 1'b0;
  logic        res;
  logic        mtick, mtip;
  logic [63:0] mtime_o;

  always #5 sys_clk = ~sys_clk;

  mtime_tick_gen_if bus();

  mtime_tick_gen #(.DIV_WIDTH(16), .DEFAULT_PRESCALE(16'd999)) dut (
    .sys_clk (sys_clk),
    .res     (res),
    .bus     (bus),
    .mtick   (mtick),
    .mtime_o (mtime_o),
    .mtip    (mtip)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state plus "cycles into current period".
  logic [63:0]  m_mtime, m_cmp, o_mtime, o_cmp;
  logic [15:0]  m_pre;
  logic         m_en, o_en;
  int unsigned  m_phase;
  logic [31:0]  m_shadow, e_rdata;
  logic         e_ack, e_mtick, e_mtip;
  bit           m_wr, m_rd, m_cfg, m_fire;

  initial forever begin
    @(posedge sys_clk);
    if (res) begin
      m_mtime = 64'd0; m_cmp = '1; m_pre = 16'd999; m_en = 1'b0; m_phase = 0;
      m_shadow = 32'd0; e_ack = 1'b0; e_rdata = 32'd0; e_mtick = 1'b0; e_mtip = 1'b0;
    end else begin
      o_mtime = m_mtime; o_cmp = m_cmp; o_en = m_en;
      m_wr   = bus.req && bus.we;
      m_rd   = bus.req && !bus.we;
      m_cfg  = m_wr && (bus.addr == 3'd4 || bus.addr == 3'd5);
      m_fire = o_en && (m_phase == m_pre) && !m_cfg;
      e_mtick = m_fire;
      e_ack   = bus.req;
      e_mtip  = (o_mtime >= o_cmp);
      e_rdata = 32'd0;
      if (m_rd) begin
        case (bus.addr)
          3'd0: begin e_rdata = o_mtime[31:0]; m_shadow = o_mtime[63:32]; end
          3'd1: e_rdata = m_shadow;
          3'd2: e_rdata = o_cmp[31:0];
          3'd3: e_rdata = o_cmp[63:32];
          3'd4: e_rdata = {16'd0, m_pre};
          3'd5: e_rdata = {31'd0, o_en};
          default: e_rdata = 32'd0;
        endcase
      end
      if (m_fire) m_mtime = o_mtime + 64'd1;
      if (m_wr) begin
        case (bus.addr)
          3'd0: m_mtime = {o_mtime[63:32], bus.wdata};
          3'd1: m_mtime = {bus.wdata, o_mtime[31:0]};
          3'd2: m_cmp[31:0] = bus.wdata;
          3'd3: m_cmp[63:32] = bus.wdata;
          3'd4: m_pre = bus.wdata[15:0];
          3'd5: m_en = bus.wdata[0];
          default: ;
        endcase
      end
      if (m_cfg || !o_en || m_fire) m_phase = 0;
      else m_phase = m_phase + 1;
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (chk_en) begin
      check("ack",   bus.ack,   e_ack);
      check("rdata", bus.rdata, e_rdata);
      check("mtick", mtick,     e_mtick);
      check("mtime", mtime_o,   m_mtime);
      check("mtip",  mtip,      e_mtip);
    end
  end

  // Bus tasks are entered and left on a falling edge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge sys_clk);
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge sys_clk);
    bus.req = 1'b0;
    check("rd_ack", bus.ack, 1'b1);
    d = bus.rdata;
  endtask

  task automatic wait_tick(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sys_clk);
      if (mtick) seen = 1;
    end
    check(name, seen, 1'b1);
  endtask

  logic [31:0] rd_v;
  logic [63:0] t0;
  int          n_pulse, last_k;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 3'd0; bus.wdata = 32'd0;
    res = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk_en = 1;
    check("rst_mtime", mtime_o, 64'd0);
    check("rst_mtip", mtip, 1'b0);
    check("rst_ack", bus.ack, 1'b0);
    res = 1'b0;

    // 1: period of four cycles
    bus_wr(3'd4, 32'd3);
    bus_wr(3'd5, 32'd1);
    n_pulse = 0; last_k = 0;
    for (int k = 0; k < 60 && n_pulse < 5; k++) begin
      @(negedge sys_clk);
      if (mtick) begin
        if (n_pulse > 0) check("t1_period", 64'(k - last_k), 64'd4);
        last_k = k;
        n_pulse++;
      end
    end
    check("t1_pulses", 64'(n_pulse), 64'd5);
    bus_rd(3'd0, rd_v);
    check("t1_lo", rd_v, 32'd5);
    check("t1_mtip", mtip, 1'b0);
    bus_wr(3'd5, 32'd0);

    // 2: tick every cycle, then freeze
    bus_wr(3'd4, 32'd0);
    bus_wr(3'd5, 32'd1);
    t0 = mtime_o;
    repeat (8) @(negedge sys_clk);
    check("t2_rate", mtime_o - t0, 64'd8);
    bus_wr(3'd5, 32'd0);
    t0 = mtime_o;
    repeat (5) @(negedge sys_clk);
    check("t2_frozen", mtime_o, t0);
    check("t2_notick", mtick, 1'b0);

    // 3: carry into the high word and full wrap
    bus_wr(3'd0, 32'hFFFF_FFFF);
    bus_wr(3'd1, 32'd0);
    bus_wr(3'd5, 32'd1);
    wait_tick("t3_tick_a");
    bus_wr(3'd5, 32'd0);
    bus_rd(3'd0, rd_v);
    check("t3_lo", rd_v, 32'd0);
    bus_rd(3'd1, rd_v);
    check("t3_hi", rd_v, 32'd1);
    bus_wr(3'd0, 32'hFFFF_FFFF);
    bus_wr(3'd1, 32'hFFFF_FFFF);
    bus_wr(3'd5, 32'd1);
    wait_tick("t3_tick_b");
    check("t3_wrap", mtime_o, 64'd0);
    check("t3_mtip_hold", mtip, 1'b1);
    bus_wr(3'd5, 32'd0);
    check("t3_mtip_drop", mtip, 1'b0);

    // 4: compare match and release
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd2, 32'd10);
    bus_wr(3'd0, 32'd0);
    bus_wr(3'd1, 32'd0);
    bus_wr(3'd5, 32'd1);
    for (int i = 0; i < 40 && mtime_o != 64'd10; i++) @(negedge sys_clk);
    check("t4_reach", mtime_o, 64'd10);
    check("t4_mtip_lat", mtip, 1'b0);
    @(negedge sys_clk);
    check("t4_mtip_rise", mtip, 1'b1);
    bus_wr(3'd3, 32'd1);
    @(negedge sys_clk);
    check("t4_mtip_clr", mtip, 1'b0);
    bus_wr(3'd5, 32'd0);

    // 5: write collides with a tick; unmapped read
    bus_wr(3'd4, 32'd3);
    bus_wr(3'd5, 32'd1);
    repeat (3) @(negedge sys_clk);
    bus_wr(3'd0, 32'd100);
    check("t5_mtick", mtick, 1'b1);
    bus_rd(3'd0, rd_v);
    check("t5_lo", rd_v, 32'd100);
    bus_wr(3'd5, 32'd0);
    bus_rd(3'd7, rd_v);
    check("t5_addr7", rd_v, 32'd0);

    // 6: reset alongside an outstanding read
    bus_wr(3'd4, 32'd3);
    bus_wr(3'd5, 32'd1);
    repeat (2) @(negedge sys_clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 3'd0; res = 1'b1;
    @(negedge sys_clk);
    bus.req = 1'b0; res = 1'b0;
    check("t6_ack", bus.ack, 1'b0);
    check("t6_rdata", bus.rdata, 32'd0);
    check("t6_mtime", mtime_o, 64'd0);
    check("t6_mtick", mtick, 1'b0);
    bus_rd(3'd2, rd_v);
    check("t6_cmp_lo", rd_v, 32'hFFFF_FFFF);
    bus_rd(3'd3, rd_v);
    check("t6_cmp_hi", rd_v, 32'hFFFF_FFFF);
    bus_rd(3'd4, rd_v);
    check("t6_pre", rd_v, 32'd999);
    bus_rd(3'd5, rd_v);
    check("t6_ctrl", rd_v, 32'd0);

    // Random traffic, checked every cycle by the model
    for (int c = 0; c < 2000; c++) begin
      res       = ($urandom_range(0, 199) == 0);
      bus.req   = ($urandom_range(0, 2) == 0);
      bus.we    = $urandom_range(0, 1);
      bus.addr  = 3'($urandom_range(0, 7));
      case (bus.addr)
        3'd4:       bus.wdata = $urandom_range(0, 5);
        3'd5:       bus.wdata = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
        3'd1, 3'd3: bus.wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1));
        default:    bus.wdata = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 60));
      endcase
      @(negedge sys_clk);
    end
    res = 1'b0; bus.req = 1'b0;
    repeat (3) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
